// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//   Idle-detect controller that drives the enable input of a ClockGate cell
//   for one gated unit. After a programmable run of idle cycles the clock is
//   gated off. Any keep condition re-enables it, and a settle delay follows
//   before the unit is reported ready again. All outputs are flops.
//
// Parameters
//   IDLE_CYCLES  idle threshold, 1..65535
//   WAKE_CYCLES  edges from enable_o rising to ready_o rising, 1..255
//
// Ports
//   clk_i           ungated free-running clock (same clock as ClockGate clk_i)
//   rst_i           synchronous, active-high reset
//   busy_i          gated unit has work in flight
//   wake_req_i      level request to run the unit; held until ready_o
//   force_on_i      override; gating is never entered while high
//   stats_clr_i     clears gated_cycles_o (stats build only)
//   enable_o        to ClockGate enable; 1 = clock runs
//   ready_o         gated clock running and stable
//   gated_cycles_o  number of cycles spent gated
//
// Build option
//   CLOCK_GATE_CTRL_STATS_EN  when defined, builds the saturating gated-cycle
//                             counter. When undefined, gated_cycles_o is tied
//                             to 0 and stats_clr_i is ignored.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ACTIVE  | clock running, unit ready, no idle run in progress
// ST_COUNTDN | clock running, counting down the idle threshold
// ST_GATED   | clock stopped
// ST_WAKING  | clock restarted, waiting for it to settle before ready

module clock_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        busy_i,
    input  logic        wake_req_i,
    input  logic        force_on_i,
    input  logic        stats_clr_i,
    output logic        enable_o,
    output logic        ready_o,
    output logic [31:0] gated_cycles_o
);

    localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    // One counter is shared by the idle countdown and the wake settle delay.
    localparam int unsigned CNT_W  = (IDLE_W > WAKE_W) ? IDLE_W : WAKE_W;

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_COUNTDN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKING = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             keep;

    assign keep = busy_i | wake_req_i | force_on_i;

    // enable_o/ready_o are written alongside each transition so they are
    // plain flops and cannot glitch into the ClockGate latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_ACTIVE;
            cnt      <= '0;
            enable_o <= 1'b1;
            ready_o  <= 1'b1;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (!keep) begin
                        state <= ST_COUNTDN;
                        cnt   <= IDLE_LOAD;
                    end
                end
                ST_COUNTDN: begin
                    // keep wins over terminal count
                    if (keep) begin
                        state <= ST_ACTIVE;
                    end else if (cnt == '0) begin
                        state    <= ST_GATED;
                        enable_o <= 1'b0;
                        ready_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GATED: begin
                    if (keep) begin
                        state    <= ST_WAKING;
                        cnt      <= WAKE_LOAD;
                        enable_o <= 1'b1;
                    end
                end
                ST_WAKING: begin
                    // Never aborts once started; the clock must settle anyway.
                    if (cnt == '0) begin
                        state   <= ST_ACTIVE;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_ACTIVE;
                    enable_o <= 1'b1;
                    ready_o  <= 1'b1;
                end
            endcase
        end
    end

`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [31:0] gated_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cnt <= '0;
        end else if (stats_clr_i) begin
            gated_cnt <= '0;
        end else if (state == ST_GATED && gated_cnt != 32'hFFFF_FFFF) begin
            gated_cnt <= gated_cnt + 32'd1;
        end
    end

    assign gated_cycles_o = gated_cnt;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign gated_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl with default parameters.
// The reference model tracks idle-run length and wake edges directly rather
// than a countdown state machine.
module tb_clock_gate_ctrl;

    localparam int unsigned IDLE = 16;
    localparam int unsigned WAKE = 2;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        busy_i = 1'b0;
    logic        wake_req_i = 1'b0;
    logic        force_on_i = 1'b0;
    logic        stats_clr_i = 1'b0;
    logic        enable_o;
    logic        ready_o;
    logic [31:0] gated_cycles_o;

    clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .busy_i         (busy_i),
        .wake_req_i     (wake_req_i),
        .force_on_i     (force_on_i),
        .stats_clr_i    (stats_clr_i),
        .enable_o       (enable_o),
        .ready_o        (ready_o),
        .gated_cycles_o (gated_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 = running, 1 = gated, 2 = waking
    int          m_mode   = 0;
    int          m_streak = 0;
    int          m_woke   = 0;
    logic [31:0] m_stat   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic busy, input logic wake,
                              input logic frc, input logic clr);
        logic keep;
        keep = busy | wake | frc;
        if (rst) begin
            m_mode = 0; m_streak = 0; m_woke = 0; m_stat = '0;
        end else begin
            if (STATS) begin
                if (clr) m_stat = '0;
                else if (m_mode == 1 && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
            end
            case (m_mode)
                0: begin
                    if (keep) m_streak = 0;
                    else begin
                        m_streak++;
                        if (m_streak == IDLE + 1) begin m_mode = 1; m_streak = 0; end
                    end
                end
                1: if (keep) begin m_mode = 2; m_woke = 0; end
                default: begin
                    m_woke++;
                    if (m_woke == WAKE) begin m_mode = 0; m_streak = 0; end
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare.
    task automatic step(input logic rst, input logic busy, input logic wake,
                        input logic frc, input logic clr);
        rst_i = rst; busy_i = busy; wake_req_i = wake; force_on_i = frc; stats_clr_i = clr;
        @(posedge clk_i);
        model_edge(rst, busy, wake, frc, clr);
        #1;
        chk("model_en", {31'd0, enable_o}, {31'd0, m_mode != 1});
        chk("model_rdy", {31'd0, ready_o}, {31'd0, m_mode == 0});
        chk("model_stat", gated_cycles_o, m_stat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int edges;
        bit fell;

        // reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_en", {31'd0, enable_o}, 32'd1);
        chk("rst_rdy", {31'd0, ready_o}, 32'd1);
        chk("rst_stat", gated_cycles_o, 32'd0);

        // idle from reset: enable through edge 16, off from edge 17
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 16) chk("idle16_en", {31'd0, enable_o}, 32'd1);
            if (i == 17) begin
                chk("idle17_en", {31'd0, enable_o}, 32'd0);
                chk("idle17_rdy", {31'd0, ready_o}, 32'd0);
            end
        end

        // wake pulse
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wake_en", {31'd0, enable_o}, 32'd1);
        chk("wake_rdy0", {31'd0, ready_o}, 32'd0);
        idle(1);
        chk("wake_rdy1", {31'd0, ready_o}, 32'd0);
        idle(1);
        chk("wake_rdy2", {31'd0, ready_o}, 32'd1);

        // countdown abort: 10 idle, 1 busy, then gating 17 edges later
        idle(10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_en", {31'd0, enable_o}, 32'd1);
        edges = 0;
        fell = 1'b0;
        while (!fell && edges < 40) begin
            idle(1);
            edges++;
            if (!enable_o) fell = 1'b1;
        end
        chk("abort_lat", edges, 32'd17);

        // force_on holds the clock for 100 idle cycles
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        fell = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (!enable_o) fell = 1'b1;
        end
        chk("force_en", {31'd0, fell}, 32'd0);

        // gated dwell statistics and clear
        idle(17);
        chk("stat_gated", {31'd0, enable_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(50);
        chk("stat_50", gated_cycles_o, STATS ? 32'd50 : 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stat_clr", gated_cycles_o, 32'd0);

        // reset mid-wake
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rw_waking", {31'd0, ready_o}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rw_en", {31'd0, enable_o}, 32'd1);
        chk("rw_rdy", {31'd0, ready_o}, 32'd1);

        // randomized segments against the model
        for (int s = 0; s < 200; s++) begin
            int len;
            int kind;
            len  = $urandom_range(1, 40);
            kind = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0: step(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 15) == 0);
                    1: step(1'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                    2: step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    default: step($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
                                  $urandom_range(0, 15) == 0, 1'b0, $urandom_range(0, 9) == 0);
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
